// File: rtl/mont_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a shared montgomery core.
// Optional WAIT-state timeout enabled by defining MONT_ARB_TIMEOUT_EN.
module mont_arbiter #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned RESW    = 5,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_i,
    input  logic            req1_i,
    input  logic [OPW-1:0]  a0_i,
    input  logic [OPW-1:0]  b0_i,
    input  logic [OPW-1:0]  a1_i,
    input  logic [OPW-1:0]  b1_i,
    output logic            gnt0_o,
    output logic            gnt1_o,
    output logic            rvalid0_o,
    output logic            rvalid1_o,
    output logic [RESW-1:0] res0_o,
    output logic [RESW-1:0] res1_o,
    output logic            rerr_o,
    output logic            busy_o,
    output logic            core_start_o,
    output logic [OPW-1:0]  core_a_o,
    output logic [OPW-1:0]  core_b_o,
    input  logic [RESW-1:0] core_c_i,
    input  logic            core_done_i
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mont_arbiter: TIMEOUT must be in 1..255");
    end
    if (RESW != OPW + 1) begin : g_bad_resw
        $error("mont_arbiter: RESW must equal OPW+1");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e          state_q;
    logic            owner_q;   // doubles as the last-served pointer
    logic            gnt0_q, gnt1_q;
    logic            rvalid0_q, rvalid1_q;
    logic            core_start_q;
    logic [RESW-1:0] res0_q, res1_q;
    logic [OPW-1:0]  core_a_q, core_b_q;
    logic            win1;

`ifdef MONT_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       rerr_q;
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);
`endif

    // On a tie the requester not served last wins.
    always_comb begin
        win1 = req1_i;
        if (req0_i && req1_i) begin
            win1 = ~owner_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            owner_q      <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            core_start_q <= 1'b0;
            res0_q       <= '0;
            res1_q       <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
`ifdef MONT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rerr_q       <= 1'b0;
`endif
        end else begin
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            core_start_q <= 1'b0;
`ifdef MONT_ARB_TIMEOUT_EN
            rerr_q       <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req0_i || req1_i) begin
                        state_q      <= StStart;
                        owner_q      <= win1;
                        core_start_q <= 1'b1;
                        if (win1) begin
                            core_a_q <= a1_i;
                            core_b_q <= b1_i;
                            gnt1_q   <= 1'b1;
                        end else begin
                            core_a_q <= a0_i;
                            core_b_q <= b0_i;
                            gnt0_q   <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    state_q <= StWait;
`ifdef MONT_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWait: begin
                    if (core_done_i) begin
                        state_q <= StIdle;
                        if (owner_q) begin
                            res1_q    <= core_c_i;
                            rvalid1_q <= 1'b1;
                        end else begin
                            res0_q    <= core_c_i;
                            rvalid0_q <= 1'b1;
                        end
`ifdef MONT_ARB_TIMEOUT_EN
                    end else if (cnt_q == CntLast) begin
                        state_q <= StIdle;
                        rerr_q  <= 1'b1;
                        if (owner_q) begin
                            res1_q    <= '0;
                            rvalid1_q <= 1'b1;
                        end else begin
                            res0_q    <= '0;
                            rvalid0_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt0_o       = gnt0_q;
    assign gnt1_o       = gnt1_q;
    assign rvalid0_o    = rvalid0_q;
    assign rvalid1_o    = rvalid1_q;
    assign res0_o       = res0_q;
    assign res1_o       = res1_q;
    assign core_start_o = core_start_q;
    assign core_a_o     = core_a_q;
    assign core_b_o     = core_b_q;
    assign busy_o       = (state_q != StIdle);
`ifdef MONT_ARB_TIMEOUT_EN
    assign rerr_o       = rerr_q;
`else
    assign rerr_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mont_arbiter.sv
// Directed bench for mont_arbiter with an adder stub core and a response scoreboard.
module tb_mont_arbiter;
    localparam int OPW  = 4;
    localparam int RESW = 5;

    logic            clk, rst;
    logic            req0, req1;
    logic [OPW-1:0]  a0, b0, a1, b1;
    logic            gnt0, gnt1, rvalid0, rvalid1, rerr, busy, core_start;
    logic [RESW-1:0] res0, res1, core_c;
    logic [OPW-1:0]  core_a, core_b;
    logic            core_done;
    logic            stub_dead;
    logic            d1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int port;
        int val;
        int err;
    } exp_t;
    exp_t sbq[$];
    int   shadow[2];

    mont_arbiter #(.OPW(OPW), .RESW(RESW), .TIMEOUT(6)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .res0_o(res0), .res1_o(res1), .rerr_o(rerr), .busy_o(busy),
        .core_start_o(core_start), .core_a_o(core_a), .core_b_o(core_b),
        .core_c_i(core_c), .core_done_i(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: c = a + b, done two cycles after start; stub_dead suppresses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1        <= 1'b0;
            core_done <= 1'b0;
            core_c    <= '0;
        end else begin
            d1        <= core_start;
            core_done <= d1 && !stub_dead;
            core_c    <= RESW'(core_a) + RESW'(core_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outs", 32'({gnt0, gnt1, rvalid0, rvalid1, rerr, core_start, busy,
                                 res0, res1, core_a, core_b}), 32'd0);
        sbq.delete();
        shadow[0] = 0;
        shadow[1] = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            check("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
            check("rvalid_gnt_overlap", 32'(gnt0 | gnt1), 32'd0);
            tests++;
            assert (sbq.size() != 0) else begin
                fails++;
                $error("FAIL rvalid_unexpected: observed rvalid0=%0b rvalid1=%0b expected none",
                       rvalid0, rvalid1);
            end
            if (sbq.size() != 0) begin
                exp_t e;
                int   p;
                e = sbq.pop_front();
                p = rvalid1 ? 1 : 0;
                check("rvalid_port", 32'(p), 32'(e.port));
                check("res_value", 32'(p ? res1 : res0), 32'(e.val));
                check("rerr", 32'(rerr), 32'(e.err));
                shadow[p] = e.val;
                check("other_res_kept", 32'(p ? res0 : res1), 32'(shadow[1-p]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        stub_dead = 1'b0;
        do_reset();

        // Single request on port 0.
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        tick();
        check("single_gnt", 32'({gnt0, gnt1, core_start, busy}), 32'b1011);
        check("single_ops", 32'({core_a, core_b}), 32'h35);
        sbq.push_back('{0, 8, 0});
        req0 = 1'b0;
        tick();
        check("single_start_pulse", 32'(core_start), 32'd0);
        tick();
        check("single_busy_wait", 32'(busy), 32'd1);
        tick();
        check("single_idle_t4", 32'(busy), 32'd0);
        tick();

        // Tie after reset: port 0 first, port 1 four cycles later.
        do_reset();
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
        req1 = 1'b1; a1 = 4'd1;  b1 = 4'd2;
        tick();
        check("tie_first_gnt", 32'({gnt0, gnt1}), 32'b10);
        sbq.push_back('{0, 30, 0});
        req0 = 1'b0;
        tick(); tick(); tick();
        check("tie_no_gnt_at_rvalid", 32'({gnt0, gnt1}), 32'b00);
        tick();
        check("tie_second_gnt", 32'({gnt0, gnt1}), 32'b01);
        check("tie_second_ops", 32'({core_a, core_b}), 32'h12);
        sbq.push_back('{1, 3, 0});
        req1 = 1'b0;
        tick(); tick(); tick();
        tick();

        // Fairness: both held, grants alternate 0,1,0,1 every 4 cycles.
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
        req1 = 1'b1; a1 = 4'd7; b1 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fair_gnt", 32'({gnt0, gnt1}), (i % 2 == 0) ? 32'b10 : 32'b01);
            if (i % 2 == 0) sbq.push_back('{0, 2, 0});
            else            sbq.push_back('{1, 9, 0});
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick(); tick();
            check("fair_gap", 32'({gnt0, gnt1}), 32'b00);
            tick();
        end
        tick();

        // Reset during WAIT drops the operation.
        req0 = 1'b1; a0 = 4'd4; b0 = 4'd4;
        tick();
        check("midrst_gnt", 32'(gnt0), 32'd1);
        sbq.push_back('{0, 8, 0});
        req0 = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd1);
        do_reset();
        req1 = 1'b1; a1 = 4'd2; b1 = 4'd2;
        tick();
        check("after_rst_gnt", 32'(gnt1), 32'd1);
        sbq.push_back('{1, 4, 0});
        req1 = 1'b0;
        tick(); tick(); tick();
        tick();

        // Give res0 a nonzero value so a timeout clear is observable.
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd3;
        tick();
        sbq.push_back('{0, 6, 0});
        req0 = 1'b0;
        tick(); tick(); tick();
        tick();

        // Dead core.
        stub_dead = 1'b1;
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
        tick();
        check("dead_gnt", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick();
`ifdef MONT_ARB_TIMEOUT_EN
        sbq.push_back('{0, 0, 1});
        tick(); tick(); tick(); tick(); tick();
        check("timeout_busy_w5", 32'(busy), 32'd1);
        tick();
        check("timeout_idle_w6", 32'(busy), 32'd0);
        check("timeout_rvalid_w6", 32'({rvalid0, rerr}), 32'b11);
        tick();
`else
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (!busy || rvalid0 || rvalid1 || rerr) bad++;
            end
            check("no_timeout_hang", 32'(bad), 32'd0);
        end
`endif
        stub_dead = 1'b0;
        do_reset();
        tick();
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mont_arbiter.md
# mont_arbiter

Two-port round-robin arbiter and sequencer for the `montgomery` compute core. It accepts operand requests from two independent requesters and grants one at a time. It latches the winner's operands, drives the core's `start`/`done` handshake, and routes the core result back to the owning requester as a one-cycle valid pulse. It sits between the bus/host-side register logic and a single shared `montgomery` instance.

## Interface
- `OPW`, 4: operand width; must match core `a`/`b` width.
- `RESW`, 5: result width; must match core `c` width (`OPW+1`).
- `TIMEOUT`, 8: WAIT-state cycle budget, range 1..255; used only with `MONT_ARB_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request; hold high with operands stable until the matching `gnt` pulse.
- `a0`, `b0`, `a1`, `b1`  in  OPW  requester operands.
- `gnt0`, `gnt1`  out  1  one-cycle pulse; operands were captured this cycle.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; result on `res0`/`res1` is new.
- `res0`, `res1`  out  RESW  per-requester result register, held until next response.
- `rerr`  out  1  qualifies the active `rvalid`; 1 means timeout. Tied 0 without macro.
- `busy`  out  1  high when state is not IDLE.
- `core_start`  out  1  to core `start`.
- `core_a`, `core_b`  out  OPW  to core `a`/`b`; registered, stable from START until next grant.
- `core_c`  in  RESW  from core `c`.
- `core_done`  in  1  from core `done`.

## Operation
- States are IDLE, START and WAIT; encoding is free.
- **IDLE:**
  - If any `req` is sampled high, pick the winner and go to START.
  - On that edge: register `core_a`/`core_b` from the winner, set the owner, and set `gntN`=1 for one cycle.
- **Winner selection:**
  - If only one requester is asserting, it wins.
  - If both assert, the requester not served last wins.
  - The last-served pointer resets to "1", so `req0` wins the first tie.
- **START:** `core_start`=1 (registered, exactly one cycle). Next state is WAIT.
- **WAIT:** on `core_done`=1:
  - register `resOWNER <= core_c` and `rvalidOWNER <= 1`, with `rerr`=0;
  - go to IDLE.
- `core_done` is ignored outside WAIT.
- The other requester's `res` register is never modified.
- A requester that keeps `req` high after its `gnt` is treated as a new request at the next IDLE.
- **Reset:**
  - Asserting `rst` at any time, including mid-operation, forces IDLE immediately.
  - The in-flight operation is dropped and no `rvalid` is produced.
  - The core must be reset alongside the arbiter (same `rst` net).
- **Reset values:**
  - `gnt*`, `rvalid*`, `rerr`, `core_start`, `busy` = 0.
  - `res0`, `res1`, `core_a`, `core_b` = 0.

## Timing
- `req` is sampled high in IDLE at cycle T.
- `gntN` and `core_start` are high at T+1 (START).
- WAIT is entered at T+2. The core raises `done` at T+3.
- `rvalidN` and new `resN` appear at T+4, while the arbiter is back in IDLE.
- Request-to-response latency is 4 cycles.
- A new request can be sampled at T+4, so peak throughput is one operation per 4 cycles.
- `busy` is high in T+1..T+3.
- **Simultaneous events:**
  - `rvalid` for the previous operation and the IDLE sampling of a new `req` happen in the same cycle; both are legal.
  - `rvalid` and the next `gnt` are never in the same cycle.

## Configuration
- **`MONT_ARB_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on WAIT entry (cycle W) and increments every WAIT cycle.
  - If `core_done` is not seen in W..W+TIMEOUT-1, the arbiter returns to IDLE at W+TIMEOUT.
  - At that cycle: `rvalidOWNER`=1, `rerr`=1, `resOWNER`=0.
  - If `core_done` arrives in the last budgeted cycle, `done` wins and `rerr`=0.
- **Not defined:**
  - WAIT waits indefinitely; no counter is synthesised.
  - `rerr` is constant 0.

## Test plan
- **Single request:** `req0` with a0=3, b0=5 at T. Expect:
  - `gnt0` and `core_start` at T+1, with core_a=3, core_b=5;
  - `rvalid0` at T+4 with res0=8, rerr=0;
  - `res1` unchanged at 0.
- **Tie after reset:** req0 (15,15) and req1 (1,2) both raised at T. Expect:
  - `gnt0` at T+1 and `rvalid0` at T+4 with res0=30;
  - `gnt1` at T+5 and `rvalid1` at T+8 with res1=3.
- **Fairness:** both `req` held high for 4 operations. Expect the grant order 0,1,0,1, with grants spaced exactly 4 cycles apart.
- **Reset mid-operation:** `rst` pulsed during WAIT. Expect:
  - all outputs 0 in the same cycle, with no `rvalid`;
  - a subsequent req1 (2,2) gives `rvalid1`, res1=4, 4 cycles later.
- **Timeout, macro on:** TIMEOUT=6 with a stub core that never asserts `done`. Expect:
  - `rvalid0`=1, `rerr`=1, res0=0 at W+6;
  - `busy` low at W+6.
- **Timeout, macro off:** same stub core. Expect `busy` to stay 1 for 100 cycles, with no `rvalid` and `rerr`=0.
